// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle: register fields and write enables in,
// PC/IF-ID enables, bubble flushes, stall counter and performance counters out.
interface hazard_ctrl_if;
    logic [4:0]  rs1_ID;
    logic [4:0]  rs2_ID;
    logic [4:0]  wrin_EX;
    logic [4:0]  wrin_MEM;
    logic [4:0]  wrin_WB;
    logic        RegWrite_EX;
    logic        RegWrite_MEM;
    logic        RegWrite_WB;
    logic        PCSrc;
    logic        PC_ENA;
    logic        IFID_ENA;
    logic        IFID_FLUSH;
    logic        IDEX_FLUSH;
    logic        EXMEM_FLUSH;
    logic [1:0]  stall_cnt;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    modport master (
        output rs1_ID, rs2_ID, wrin_EX, wrin_MEM, wrin_WB,
        output RegWrite_EX, RegWrite_MEM, RegWrite_WB, PCSrc,
        input  PC_ENA, IFID_ENA, IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH,
        input  stall_cnt, stall_count, flush_count
    );

    modport slave (
        input  rs1_ID, rs2_ID, wrin_EX, wrin_MEM, wrin_WB,
        input  RegWrite_EX, RegWrite_MEM, RegWrite_WB, PCSrc,
        output PC_ENA, IFID_ENA, IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH,
        output stall_cnt, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Data-hazard stall / branch-flush controller for a 5-stage pipeline.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush performance counters.
module hazard_ctrl (
    input  logic         CLK,
    input  logic         RESET,
    hazard_ctrl_if.slave hz
);
    typedef enum logic {RUN, STALL} state_t;

    state_t      state_reg;
    logic [1:0]  stall_cnt_reg;
    logic [2:0]  hit;
    logic [4:0]  wrin [3];
    logic [2:0]  reg_write;
    logic [1:0]  need_cnt;
    logic        stall_active;
    logic        flush_active;

    assign wrin[0]   = hz.wrin_EX;
    assign wrin[1]   = hz.wrin_MEM;
    assign wrin[2]   = hz.wrin_WB;
    assign reg_write = {hz.RegWrite_WB, hz.RegWrite_MEM, hz.RegWrite_EX};

    // Conservative compare: both rs fields checked for every opcode, index 0 = EX.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_hit
            assign hit[gi] = reg_write[gi] && (wrin[gi] != 5'd0) &&
                             ((wrin[gi] == hz.rs1_ID) || (wrin[gi] == hz.rs2_ID));
        end
    endgenerate

    always_comb begin
        need_cnt = 2'd0;
        if (hit[0])      need_cnt = 2'd3;
        else if (hit[1]) need_cnt = 2'd2;
        else if (hit[2]) need_cnt = 2'd1;
    end

    assign flush_active = !RESET && hz.PCSrc;
    assign stall_active = !RESET && !hz.PCSrc &&
                          ((state_reg == STALL) || (need_cnt != 2'd0));

    // Outputs are combinational so a hazard stalls in the very cycle it is seen.
    assign hz.PC_ENA      = !stall_active;
    assign hz.IFID_ENA    = !stall_active;
    assign hz.IFID_FLUSH  = flush_active;
    assign hz.IDEX_FLUSH  = flush_active || stall_active;
    assign hz.EXMEM_FLUSH = flush_active;
    assign hz.stall_cnt   = stall_cnt_reg;

    always_ff @(posedge CLK) begin
        if (RESET || hz.PCSrc) begin
            state_reg     <= RUN;
            stall_cnt_reg <= 2'd0;
        end else if (state_reg == STALL) begin
            stall_cnt_reg <= (stall_cnt_reg != 2'd0) ? stall_cnt_reg - 2'd1 : 2'd0;
            if (stall_cnt_reg <= 2'd1)
                state_reg <= RUN;
        end else if (need_cnt != 2'd0) begin
            stall_cnt_reg <= need_cnt - 2'd1;
            state_reg     <= (need_cnt > 2'd1) ? STALL : RUN;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_count_reg;
    logic [31:0] flush_count_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_count_reg <= 32'd0;
            flush_count_reg <= 32'd0;
        end else begin
            if (stall_active && (stall_count_reg != 32'hFFFF_FFFF))
                stall_count_reg <= stall_count_reg + 32'd1;
            if (flush_active && (flush_count_reg != 32'hFFFF_FFFF))
                flush_count_reg <= flush_count_reg + 32'd1;
        end
    end

    assign hz.stall_count = stall_count_reg;
    assign hz.flush_count = flush_count_reg;
`else
    assign hz.stall_count = 32'd0;
    assign hz.flush_count = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed table-driven bench for hazard_ctrl: one vector per clock cycle, state carried
// across vectors, plus a hand sequence for the performance counters.
module tb_hazard_ctrl;
    logic CLK = 1'b0;
    logic RESET;
    hazard_ctrl_if hz ();

    hazard_ctrl dut (.CLK(CLK), .RESET(RESET), .hz(hz));

    always #5 CLK = ~CLK;

    // exp_out = {PC_ENA, IFID_ENA, IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH}
    typedef struct {
        logic       rst;
        logic       pcsrc;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] wex;
        logic [4:0] wmem;
        logic [4:0] wwb;
        logic [2:0] rw;      // {WB, MEM, EX}
        logic [4:0] exp_out;
        logic [1:0] exp_cnt; // stall_cnt after the edge
    } vec_t;

    localparam logic [4:0] O_RUN   = 5'b11000;
    localparam logic [4:0] O_STALL = 5'b00010;
    localparam logic [4:0] O_FLUSH = 5'b11111;

    int checks = 0;
    int errors = 0;
    int exp_stalls = 0;
    int exp_flushes = 0;
    vec_t vecs [32];

    function automatic vec_t mk(logic rst, logic pcsrc, logic [4:0] rs1, logic [4:0] rs2,
                                logic [4:0] wex, logic [4:0] wmem, logic [4:0] wwb,
                                logic [2:0] rw, logic [4:0] exp_out, logic [1:0] exp_cnt);
        vec_t v;
        v.rst = rst; v.pcsrc = pcsrc; v.rs1 = rs1; v.rs2 = rs2;
        v.wex = wex; v.wmem = wmem; v.wwb = wwb; v.rw = rw;
        v.exp_out = exp_out; v.exp_cnt = exp_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        logic [4:0] outs;
        @(negedge CLK);
        RESET          = v.rst;
        hz.PCSrc       = v.pcsrc;
        hz.rs1_ID      = v.rs1;
        hz.rs2_ID      = v.rs2;
        hz.wrin_EX     = v.wex;
        hz.wrin_MEM    = v.wmem;
        hz.wrin_WB     = v.wwb;
        hz.RegWrite_EX  = v.rw[0];
        hz.RegWrite_MEM = v.rw[1];
        hz.RegWrite_WB  = v.rw[2];
        #1;
        outs = {hz.PC_ENA, hz.IFID_ENA, hz.IFID_FLUSH, hz.IDEX_FLUSH, hz.EXMEM_FLUSH};
        check($sformatf("v%0d_outputs", idx), {27'd0, outs}, {27'd0, v.exp_out});
        @(posedge CLK);
        #1;
        if (v.rst) begin
            exp_stalls  = 0;
            exp_flushes = 0;
        end else begin
            if (!v.exp_out[4]) exp_stalls++;
            if (v.pcsrc) exp_flushes++;
        end
        check($sformatf("v%0d_stall_cnt", idx), {30'd0, hz.stall_cnt}, {30'd0, v.exp_cnt});
`ifdef HAZARD_PERF_CNT_EN
        check($sformatf("v%0d_stall_count", idx), hz.stall_count, exp_stalls);
        check($sformatf("v%0d_flush_count", idx), hz.flush_count, exp_flushes);
`else
        check($sformatf("v%0d_stall_count", idx), hz.stall_count, 32'd0);
        check($sformatf("v%0d_flush_count", idx), hz.flush_count, 32'd0);
`endif
        $display("vec %0d rst=%0b pcsrc=%0b outs=%05b stall_cnt=%0d stall_count=%0d flush_count=%0d",
                 idx, v.rst, v.pcsrc, outs, hz.stall_cnt, hz.stall_count, hz.flush_count);
    endtask

    initial begin
        RESET = 1'b1;
        hz.PCSrc = 1'b0;
        hz.rs1_ID = 5'd0; hz.rs2_ID = 5'd0;
        hz.wrin_EX = 5'd0; hz.wrin_MEM = 5'd0; hz.wrin_WB = 5'd0;
        hz.RegWrite_EX = 1'b0; hz.RegWrite_MEM = 1'b0; hz.RegWrite_WB = 1'b0;

        //           rst pc  rs1 rs2 wex wmem wwb rw       expected    cnt
        vecs[0]  = mk(1, 1,  5,  0,  5,  0,   0,  3'b001, O_RUN,   0); // reset beats branch+hazard
        vecs[1]  = mk(0, 0,  0,  0,  0,  0,   0,  3'b000, O_RUN,   0);
        vecs[2]  = mk(0, 0,  5,  0,  5,  0,   0,  3'b001, O_STALL, 2); // EX hit: 3 stalls
        vecs[3]  = mk(0, 0,  5,  0,  5,  0,   0,  3'b001, O_STALL, 1);
        vecs[4]  = mk(0, 0,  5,  0,  5,  0,   0,  3'b001, O_STALL, 0);
        vecs[5]  = mk(0, 0,  0,  0,  0,  0,   0,  3'b000, O_RUN,   0);
        vecs[6]  = mk(0, 0,  0,  7,  0,  7,   0,  3'b010, O_STALL, 1); // MEM hit: 2 stalls
        vecs[7]  = mk(0, 0,  0,  7,  0,  7,   0,  3'b010, O_STALL, 0);
        vecs[8]  = mk(0, 0,  0,  0,  0,  0,   0,  3'b000, O_RUN,   0);
        vecs[9]  = mk(0, 0,  3,  0,  0,  0,   3,  3'b100, O_STALL, 0); // WB hit: 1 stall
        vecs[10] = mk(0, 0,  0,  0,  0,  0,   0,  3'b000, O_RUN,   0);
        vecs[11] = mk(0, 0,  0,  0,  0,  0,   0,  3'b001, O_RUN,   0); // x0 never hazards
        vecs[12] = mk(0, 0,  5,  0,  5,  0,   0,  3'b000, O_RUN,   0); // write disabled
        vecs[13] = mk(0, 0,  5,  7,  5,  7,   0,  3'b011, O_STALL, 2); // EX beats MEM
        vecs[14] = mk(0, 0,  0,  0,  0,  0,   0,  3'b000, O_STALL, 1); // STALL ignores inputs
        vecs[15] = mk(0, 0,  0,  0,  0,  0,   0,  3'b000, O_STALL, 0);
        vecs[16] = mk(0, 0,  0,  0,  0,  0,   0,  3'b000, O_RUN,   0);
        vecs[17] = mk(0, 0,  5,  0,  5,  0,   0,  3'b001, O_STALL, 2);
        vecs[18] = mk(0, 1,  5,  0,  5,  0,   0,  3'b001, O_FLUSH, 0); // branch aborts stall
        vecs[19] = mk(0, 0,  0,  0,  0,  0,   0,  3'b000, O_RUN,   0);
        vecs[20] = mk(0, 1,  0,  7,  0,  7,   0,  3'b010, O_FLUSH, 0); // branch beats hazard
        vecs[21] = mk(0, 0,  0,  0,  0,  0,   0,  3'b000, O_RUN,   0);
        vecs[22] = mk(0, 0,  0,  7,  0,  7,   0,  3'b010, O_STALL, 1);
        vecs[23] = mk(0, 0,  0,  7,  0,  7,   0,  3'b010, O_STALL, 0);
        vecs[24] = mk(0, 0,  0,  7,  0,  7,   0,  3'b010, O_STALL, 1); // back-to-back restart
        vecs[25] = mk(0, 0,  3,  0,  0,  0,   3,  3'b100, O_STALL, 0);
        vecs[26] = mk(0, 0,  0,  0,  0,  0,   0,  3'b000, O_RUN,   0);
        vecs[27] = mk(0, 0,  5,  0,  5,  0,   0,  3'b001, O_STALL, 2);
        vecs[28] = mk(1, 0,  5,  0,  5,  0,   0,  3'b001, O_RUN,   0); // reset mid-stall
        vecs[29] = mk(0, 0,  0,  0,  0,  0,   0,  3'b000, O_RUN,   0);
        vecs[30] = mk(0, 0,  3,  0,  0,  0,   3,  3'b100, O_STALL, 0);
        vecs[31] = mk(0, 0,  0,  0,  0,  0,   0,  3'b000, O_RUN,   0);

        for (int i = 0; i < 32; i++)
            apply_vec(vecs[i], i);

        // One EX hazard plus one taken branch from a clean reset.
        apply_vec(mk(1, 0, 0, 0, 0, 0, 0, 3'b000, O_RUN,   0), 100);
        apply_vec(mk(0, 0, 9, 0, 9, 0, 0, 3'b001, O_STALL, 2), 101);
        apply_vec(mk(0, 0, 9, 0, 9, 0, 0, 3'b001, O_STALL, 1), 102);
        apply_vec(mk(0, 0, 9, 0, 9, 0, 0, 3'b001, O_STALL, 0), 103);
        apply_vec(mk(0, 0, 0, 0, 0, 0, 0, 3'b000, O_RUN,   0), 104);
        apply_vec(mk(0, 1, 0, 0, 0, 0, 0, 3'b000, O_FLUSH, 0), 105);
        apply_vec(mk(0, 0, 0, 0, 0, 0, 0, 3'b000, O_RUN,   0), 106);
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall_count", hz.stall_count, 32'd3);
        check("perf_flush_count", hz.flush_count, 32'd1);
`else
        check("perf_stall_count", hz.stall_count, 32'd0);
        check("perf_flush_count", hz.flush_count, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have the port `CLK`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `RESET`, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the ports `rs1_ID` and `rs2_ID`, input, 5 bits each: source register fields of the instruction in ID.
REQ-004 The block SHALL have the ports `wrin_EX`, `wrin_MEM` and `wrin_WB`, input, 5 bits each: destination register of each stage.
REQ-005 The block SHALL have the ports `RegWrite_EX`, `RegWrite_MEM` and `RegWrite_WB`, input, 1 bit each: register write enable of each stage.
REQ-006 The block SHALL have the port `PCSrc`, input, 1 bit: taken branch resolved in MEM.
REQ-007 The block SHALL have the port `PC_ENA`, output, 1 bit: PC register load enable.
REQ-008 The block SHALL have the port `IFID_ENA`, output, 1 bit: IF/ID register load enable.
REQ-009 The block SHALL have the ports `IFID_FLUSH`, `IDEX_FLUSH` and `EXMEM_FLUSH`, output, 1 bit each: on the next edge, the named register loads a bubble (all controls 0).
REQ-010 The block SHALL have the port `stall_cnt`, output, 2 bits: remaining stall cycles after the current one.
REQ-011 The block SHALL have the ports `stall_count` and `flush_count`, output, 32 bits each: performance counters.

Function
REQ-012 Hazard terms SHALL be hit_X = RegWrite_X & (wrin_X != 0) & ((wrin_X == rs1_ID) | (wrin_X == rs2_ID)), for X in EX, MEM, WB.
REQ-013 Hazard comparison SHALL be conservative: rs fields are compared for every opcode, and false stalls (LUI, JAL) are accepted.
REQ-014 Required stall length N SHALL be 3 if hit_EX, else 2 if hit_MEM, else 1 if hit_WB, else 0; EX takes priority.
REQ-015 The FSM SHALL have the states RUN and STALL.
REQ-016 In RUN with PCSrc=0 and N=0: PC_ENA=1 and IFID_ENA=1, and all FLUSH outputs SHALL be 0.
REQ-017 In RUN with PCSrc=0 and N>0, the current cycle SHALL be a stall cycle: PC_ENA=0, IFID_ENA=0, IDEX_FLUSH=1, and the other flushes 0.
REQ-018 On that RUN stall edge, stall_cnt SHALL be loaded with N-1; the FSM goes to STALL if N-1>0, else stays in RUN.
REQ-019 In STALL with PCSrc=0, the stall outputs of REQ-017 SHALL be asserted and the hazard terms ignored.
REQ-020 In STALL with PCSrc=0, stall_cnt SHALL decrement on each edge, returning to RUN on the edge where stall_cnt==1 (stall_cnt becomes 0).
REQ-021 PCSrc=1 in any state SHALL assert PC_ENA=1, IFID_ENA=1, IFID_FLUSH=1, IDEX_FLUSH=1 and EXMEM_FLUSH=1.
REQ-022 On a PCSrc=1 edge, stall_cnt SHALL be set to 0 and the FSM to RUN.
REQ-023 Flush SHALL override stall whenever PCSrc and a hazard or STALL coincide; a pending stall is aborted.
REQ-024 Latency SHALL be zero: all outputs are combinational from state, stall_cnt and inputs within the same cycle.
REQ-025 A back-to-back dependency detected in RUN on the cycle after a stall completes SHALL start a new stall normally.
REQ-026 stall_cnt SHALL never exceed 2 and SHALL never wrap below 0.

Reset
REQ-027 With RESET=1 at an edge, the FSM SHALL go to RUN, stall_cnt to 0, and stall_count and flush_count to 0.
REQ-028 During RESET=1, the outputs SHALL be PC_ENA=1 and IFID_ENA=1, with all FLUSH=0.
REQ-029 RESET SHALL override PCSrc and hazards.
REQ-030 A RESET asserted mid-stall SHALL abort the stall; the first cycle after RESET deasserts is evaluated from RUN.

Configuration
REQ-031 With macro HAZARD_PERF_CNT_EN defined, stall_count SHALL increment once per stall cycle (REQ-017 or REQ-019 outputs active).
REQ-032 With HAZARD_PERF_CNT_EN defined, flush_count SHALL increment once per PCSrc=1 cycle.
REQ-033 With HAZARD_PERF_CNT_EN defined, both counters SHALL saturate at 32'hFFFF_FFFF.
REQ-034 Without HAZARD_PERF_CNT_EN, stall_count and flush_count SHALL be constant 0 and no counter registers SHALL be synthesized.

Verification
REQ-035 Scenario 1: rs1_ID=5, wrin_EX=5, RegWrite_EX=1 in RUN -> PC_ENA=0 for exactly 3 consecutive cycles, IDEX_FLUSH=1 in each, and stall_cnt sequence 2,1,0 after each edge.
REQ-036 Scenario 2: rs2_ID=7, wrin_MEM=7, RegWrite_MEM=1 with no EX hit -> 2 stall cycles; wrin_WB hit only -> 1 stall cycle, FSM stays in RUN.
REQ-037 Scenario 3: wrin_EX=0, RegWrite_EX=1, rs1_ID=0 -> no stall; wrin_EX=5 with RegWrite_EX=0 -> no stall.
REQ-038 Scenario 4: PCSrc=1 on the 2nd cycle of a 3-cycle stall -> all three FLUSH outputs=1 and PC_ENA=1 that cycle; stall_cnt=0 and FSM in RUN next cycle.
REQ-039 Scenario 5: RESET=1 while stall_cnt=2 -> next cycle stall_cnt=0, PC_ENA=1, and both counters 0.
REQ-040 Scenario 6 (HAZARD_PERF_CNT_EN defined): one EX hazard plus one taken branch -> stall_count=3 and flush_count=1; with the macro undefined, both read 0.
